// File: rtl/stopwatch_lap_core_if.sv
// Button, digit and lap-readout bundle for stopwatch_lap_core.
// master drives buttons and lap_pop; slave (the core) drives digits and lap status.
interface stopwatch_lap_core_if;
  logic        start_n;
  logic        stop_n;
  logic        lap_n;
  logic        lap_pop;
  logic [3:0]  d;
  logic [3:0]  e;
  logic [3:0]  f;
  logic [3:0]  g;
  logic [3:0]  h;
  logic [3:0]  i;
  logic        running;
  logic [23:0] lap_data;
  logic        lap_empty;
  logic        lap_full;
  logic        lap_ovf;

  modport master (
    output start_n, stop_n, lap_n, lap_pop,
    input  d, e, f, g, h, i, running, lap_data, lap_empty, lap_full, lap_ovf
  );

  modport slave (
    input  start_n, stop_n, lap_n, lap_pop,
    output d, e, f, g, h, i, running, lap_data, lap_empty, lap_full, lap_ovf
  );
endinterface

// File: rtl/stopwatch_lap_core.sv
// Six-digit BCD stopwatch (mm:ss.cc) with synchronised start/stop buttons.
// Define STOPWATCH_LAP_EN to build the lap-capture FIFO and sticky overflow flag.
module stopwatch_lap_core #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stopwatch_lap_core_if.slave  bus
);
  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DIG_W = 24;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [1:0]       btn_s1, btn_s2, btn_prev;
  logic             start_press, stop_press, tick_c;
  logic [PRE_W-1:0] presc;
  logic [DIG_W-1:0] digits, digits_inc;
  logic             running_q;
  logic             carry;

  // {stop, start} two-flop synchroniser plus previous value for press detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1   <= '1;
      btn_s2   <= '1;
      btn_prev <= '1;
    end else begin
      btn_s1   <= {bus.stop_n, bus.start_n};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign start_press = btn_prev[0] & ~btn_s2[0];
  assign stop_press  = btn_prev[1] & ~btn_s2[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Stop overrides start; tick fires on the prescaler terminal count while running
  always_comb begin
    state_nx = state;
    tick_c   = 1'b0;
    if (stop_press) begin
      state_nx = IDLE;
    end else if (start_press) begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = PAUSE;
        PAUSE:   state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
    tick_c = (state == RUN) && (presc == PRE_W'(DIV - 1));
  end

  // Ripple BCD increment; the seconds-tens digit (index 3) wraps at 5
  always_comb begin
    digits_inc = digits;
    carry      = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (carry) begin
        if (digits[4*k +: 4] == ((k == 3) ? 4'd5 : 4'd9)) begin
          digits_inc[4*k +: 4] = 4'd0;
        end else begin
          digits_inc[4*k +: 4] = digits[4*k +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      digits    <= '0;
      running_q <= 1'b0;
    end else begin
      running_q <= (state_nx == RUN);
      if (stop_press || state == IDLE || tick_c) presc <= '0;
      else if (state == RUN)                     presc <= presc + PRE_W'(1);
      if (stop_press)  digits <= '0;
      else if (tick_c) digits <= digits_inc;
    end
  end

  assign bus.d       = digits[23:20];
  assign bus.e       = digits[19:16];
  assign bus.f       = digits[15:12];
  assign bus.g       = digits[11:8];
  assign bus.h       = digits[7:4];
  assign bus.i       = digits[3:0];
  assign bus.running = running_q;

`ifdef STOPWATCH_LAP_EN
  localparam int unsigned PTR_W  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int unsigned LCNT_W = PTR_W + 1;

  logic              lap_s1, lap_s2, lap_prev, lap_press;
  logic [DIG_W-1:0]  lap_mem [LAP_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_nx;
  logic [LCNT_W-1:0] lap_cnt, cnt_nx;
  logic              push_c, pop_c, ovf_c, lap_req_c;
  logic [DIG_W-1:0]  head_nx;
  logic [DIG_W-1:0]  lap_data_q;
  logic              lap_empty_q, lap_full_q, lap_ovf_q;

  assign lap_press = lap_prev & ~lap_s2;

  // Pop before push, so a full FIFO accepts a capture when popped in the same cycle
  always_comb begin
    lap_req_c = lap_press && (state != IDLE);
    pop_c     = bus.lap_pop && (lap_cnt != '0);
    push_c    = lap_req_c && ((lap_cnt != LCNT_W'(LAP_DEPTH)) || pop_c);
    ovf_c     = lap_req_c && (lap_cnt == LCNT_W'(LAP_DEPTH)) && !pop_c;
    rd_nx     = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    cnt_nx    = lap_cnt + LCNT_W'(push_c) - LCNT_W'(pop_c);
    head_nx   = '0;
    if (cnt_nx != '0) head_nx = (push_c && rd_nx == wr_ptr) ? digits : lap_mem[rd_nx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_s1      <= 1'b1;
      lap_s2      <= 1'b1;
      lap_prev    <= 1'b1;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      lap_cnt     <= '0;
      lap_data_q  <= '0;
      lap_empty_q <= 1'b1;
      lap_full_q  <= 1'b0;
      lap_ovf_q   <= 1'b0;
    end else begin
      lap_s1   <= bus.lap_n;
      lap_s2   <= lap_s1;
      lap_prev <= lap_s2;
      if (stop_press) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        lap_cnt     <= '0;
        lap_data_q  <= '0;
        lap_empty_q <= 1'b1;
        lap_full_q  <= 1'b0;
        lap_ovf_q   <= 1'b0;
      end else begin
        rd_ptr      <= rd_nx;
        lap_cnt     <= cnt_nx;
        lap_data_q  <= head_nx;
        lap_empty_q <= (cnt_nx == '0);
        lap_full_q  <= (cnt_nx == LCNT_W'(LAP_DEPTH));
        if (push_c) wr_ptr    <= wr_ptr + PTR_W'(1);
        if (ovf_c)  lap_ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c && !stop_press) lap_mem[wr_ptr] <= digits;
  end

  assign bus.lap_data  = lap_data_q;
  assign bus.lap_empty = lap_empty_q;
  assign bus.lap_full  = lap_full_q;
  assign bus.lap_ovf   = lap_ovf_q;
`else
  logic unused_lap;
  assign unused_lap    = bus.lap_n ^ bus.lap_pop;
  assign bus.lap_data  = '0;
  assign bus.lap_empty = 1'b1;
  assign bus.lap_full  = 1'b0;
  assign bus.lap_ovf   = 1'b0;
`endif
endmodule

// File: doc/stopwatch_lap_core.md
# stopwatch_lap_core

Parametrised stopwatch core with six BCD digits (mm:ss.cc), start/pause/clear control from active-low push buttons, and an optional lap-capture FIFO. It is the next generation of the top-level stopwatch: tick rate and clock frequency are parameters, button handling includes synchronisation and edge detection, and lap times are buffered for readout. It sits between board buttons and the 7-segment driver.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- TICK_HZ, 100, count rate in Hz (one LSB = one centisecond at default)
- LAP_DEPTH, 4, lap FIFO entries (power of two, ≥2)
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start_n  input  1  start/pause button, active-low, asynchronous to clk
- stop_n  input  1  stop/clear button, active-low, asynchronous to clk
- lap_n  input  1  lap-capture button, active-low, asynchronous to clk
- lap_pop  input  1  active-high, one cycle: remove head of lap FIFO
- d, e, f, g, h, i  output  4 each  BCD digits: d/e minutes tens/ones, f/g seconds tens/ones, h/i centiseconds tens/ones
- running  output  1  high in RUN
- lap_data  output  24  FIFO head {d,e,f,g,h,i}; zero when empty
- lap_empty, lap_full  output  1 each  FIFO status
- lap_ovf  output  1  sticky: a capture was dropped because the FIFO was full

## Operation
- States: IDLE (T0), RUN (T1), PAUSE (T2). Reset -> IDLE.
- start press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
- stop press: any state -> IDLE; digits and prescaler cleared; lap FIFO and lap_ovf cleared.
- start and stop press in the same cycle: stop wins.
- Button path per input: two-flop synchroniser (reset value 1) plus a previous-value flop; a press is one cycle when synced value goes 1->0. Holding a button produces one press.
- Prescaler: DIV = CLK_HZ/TICK_HZ (integer, ≥2). Counts 0..DIV-1 in RUN only; held in PAUSE; cleared in IDLE. Tick at terminal count.
- Digit chain per tick: i 0-9 carries to h 0-9 -> g 0-9 -> f 0-5 -> e 0-9 -> d 0-9. 99:59.99 + tick -> 00:00.00 (wrap, no flag).
- Lap press in RUN or PAUSE: push current digits. Full: entry dropped, lap_ovf set. Lap press in IDLE ignored.
- lap_pop while empty: ignored. Push and pop in the same cycle when full: pop then push, no overflow. Push and pop when empty: push only.

## Timing
- Reset values: all digits 0, running 0, lap_data 0, lap_empty 1, lap_full 0, lap_ovf 0.
- Button latency: edge N samples low; state/FIFO change visible after edge N+2.
- First tick after entering RUN from IDLE: DIV cycles after running rises; digits update on the tick edge.
- PAUSE->RUN resumes prescaler phase; the next tick arrives after the remaining count.
- A capture taken on a tick edge records the pre-tick value.
- lap_pop takes effect on the next edge; lap_data/status update in the same edge.
- reset_n low mid-count: all state clears immediately, asynchronously.

## Configuration
- STOPWATCH_LAP_EN defined: lap synchroniser, FIFO and lap_ovf built as above.
- Undefined: no lap logic; lap_n and lap_pop ignored; lap_data 0, lap_empty 1, lap_full 0, lap_ovf 0 constant. Stopwatch behaviour unchanged.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10): reset, start press, run 1000 cycles -> digits 00:01.00, running 1.
- Start, start (pause), wait 500 cycles, start -> digits frozen during pause; count resumes with preserved phase; no tick lost or doubled.
- Run to 00:59.99 then one tick -> f/g/h/i = 0,0,0,0, e=1; run to 99:59.99 -> wraps to 00:00.00.
- Start and stop pressed in the same cycle during RUN -> IDLE, all digits 0.
- With STOPWATCH_LAP_EN, LAP_DEPTH=4: five laps -> lap_full 1, lap_ovf 1, pops return first four captures in order, then lap_empty 1, lap_data 0.
- Without STOPWATCH_LAP_EN: lap presses -> lap_empty stays 1, lap_ovf 0, digits unaffected.
